piso_serializer: RTL
====================

// Module: piso_serializer
// PURPOSE
//   Parallel-in serial-out stage that consumes the N-bit word produced by the
//   parallel register stage and shifts it out one bit per clock.
//   Valid/ready load handshake, valid-qualified serial output, done pulse on last bit.
//   Gapless back-to-back words: the next word loads in the cycle its predecessor's
//   last bit is driven.
// PARAMETERS
//   N          4   word width in bits (N >= 1)
//   MSB_FIRST  1   1: shift out pi[N-1] first; 0: shift out pi[0] first
// PORTS
//   clk         input   1   single clock, all state updates on posedge
//   rst         input   1   reset, asynchronous, active-high
//   pi          input   N   parallel word, sampled only on an accepted load
//   load_valid  input   1   upstream offers pi this cycle
//   load_ready  output  1   block can accept a word this cycle
//   so          output  1   serial data bit
//   so_valid    output  1   so carries a valid bit this cycle
//   done        output  1   so carries the last bit of the current word
// BEHAVIOUR
//   Registers: state {IDLE, SHIFT}, shreg[N-1:0], cnt[max(1,$clog2(N))-1:0].
//   Outputs (combinational from registers only, no input-to-output paths):
//     so       = MSB_FIRST ? shreg[N-1] : shreg[0]
//     so_valid = (state == SHIFT)
//     done     = so_valid && (cnt == 0)
//     load_ready = (state == IDLE) || done
//   Accept = load_valid && load_ready at a posedge.
//   On accept: shreg <= pi; cnt <= N-1; state <= SHIFT.
//   SHIFT, cnt != 0: shreg shifts toward the output end (zero fill); cnt <= cnt-1.
//   SHIFT, cnt == 0 (done): accept -> reload as above (no idle gap);
//     else state <= IDLE, shreg <= 0.
//   IDLE without accept: all registers hold; so stays 0.
//   Latency: word accepted at edge k drives bits in cycles k+1 .. k+N;
//     done is high in cycle k+N only.
//   N == 1: cnt loads 0; the single bit is driven with done high in cycle k+1.
//   load_valid while busy (SHIFT, cnt != 0): ignored, load_ready = 0, not queued.
//   pi changes outside an accept edge have no effect on the word in flight.
//   Reset (asynchronous, takes effect without a clock edge):
//     state = IDLE, shreg = 0, cnt = 0.
//     Hence so = 0, so_valid = 0, done = 0, load_ready = 1.
//     Reset mid-word aborts it; no done is produced for the aborted word.
//   First accept is possible at the first posedge after rst deasserts.
// TESTING
//   1 Reset: rst=1 from t=0
//     -> so=0, so_valid=0, done=0, load_ready=1 before any clock edge.
//   2 Single word, N=4, MSB_FIRST=1: pi=4'b1100 with load_valid for one cycle
//     -> so=1,1,0,0 with so_valid=1 for 4 cycles;
//        done only on the 4th cycle; load_ready=0 in cycles 1-3, then 1.
//   3 Back-to-back: load_valid held high with 4'b1100, then 4'b0011 at the done cycle
//     -> 8 consecutive valid bits 1,1,0,0,0,0,1,1; done in cycles 4 and 8; no gap.
//   4 LSB first (MSB_FIRST=0): pi=4'b1101 -> so=1,0,1,1.
//   5 Busy rejection: after accepting 4'b1010, drive pi=4'b0101 with load_valid=1 during shift
//     -> output stays 1,0,1,0; 4'b0101 accepted only at the done cycle, then shifted out.
//   6 Async reset mid-word: assert rst between edges after 2 bits of 4'b1100
//     -> so_valid/so drop to 0 immediately, no done;
//        after release, 4'b0110 shifts out cleanly as 0,1,1,0.

Source files
------------

// File: rtl/piso_serializer_if.sv
// Load handshake and valid-qualified serial output bundle for piso_serializer.
// The master side offers parallel words and consumes the serial stream.
interface piso_serializer_if #(
    parameter int N = 4
);
    logic [N-1:0] pi;
    logic         load_valid;
    logic         load_ready;
    logic         so;
    logic         so_valid;
    logic         done;

    modport master (
        output pi, load_valid,
        input  load_ready, so, so_valid, done
    );

    modport slave (
        input  pi, load_valid,
        output load_ready, so, so_valid, done
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter: a word accepted at edge k drives bits in cycles k+1..k+N, with done on the last bit.
// load_ready drops while a word is in flight and returns on its done cycle, so back-to-back words load with no gap.
module piso_serializer #(
    parameter int N         = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    piso_serializer_if.slave bus
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [N-1:0]    shreg;
    logic [N-1:0]    shreg_nxt;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;
    logic            accept;
    logic            last_bit;

    // Outputs depend on registers only; load_valid never reaches them combinationally.
    assign last_bit       = (state == SHIFT) && (cnt == '0);
    assign bus.so         = MSB_FIRST ? shreg[N-1] : shreg[0];
    assign bus.so_valid   = (state == SHIFT);
    assign bus.done       = last_bit;
    assign bus.load_ready = (state == IDLE) || last_bit;
    assign accept         = bus.load_valid && bus.load_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            shreg <= shreg_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        cnt_nxt   = cnt;
        if (accept) begin
            state_nxt = SHIFT;
            shreg_nxt = bus.pi;
            cnt_nxt   = CW'(N - 1);
        end else if (state == SHIFT) begin
            if (cnt != '0) begin
                shreg_nxt = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
                cnt_nxt   = cnt - CW'(1);
            end else begin
                // Clearing the register keeps so low while idle.
                state_nxt = IDLE;
                shreg_nxt = '0;
            end
        end
    end
endmodule
